myproject_sdiv_24s_9s_seq: RTL and testbench

MYPROJECT_SDIV_24S_9S_SEQ -- requirements
Module: myproject_sdiv_24s_9s_seq

---
 rtl/myproject_sdiv_pkg.sv | 15 +
 rtl/myproject_sdiv_step.sv | 25 ++
 rtl/myproject_sdiv_24s_9s_seq.sv | 195 +++++++++++++++++++
 tb/tb_myproject_sdiv_24s_9s_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_sdiv_pkg.sv
// Shared widths, counter size and FSM state type for the 24/9 sequential signed divider.
package myproject_sdiv_pkg;

  localparam int SDIV_DIVIDEND_W = 24;
  localparam int SDIV_DIVISOR_W  = 9;
  localparam int SDIV_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_e;

endpackage

// File: rtl/myproject_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
// Combinational; the partial remainder always stays below the divisor magnitude.
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
#(
  parameter int W = SDIV_DIVISOR_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, div_i};

  // A borrow out of the top bit means the divisor did not fit: restore.
  assign q_o   = ~trial[W];
  assign rem_o = q_o ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/myproject_sdiv_24s_9s_seq.sv
// Sequential signed divider (truncating), one quotient bit per enabled cycle; MYPROJECT_SDIV_SAT_EN saturates overflow.
// Latency 26 enabled edges accept->out_valid; in_ready only in IDLE, result held in DONE until out_ready.
module myproject_sdiv_24s_9s_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = SDIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = SDIV_DIVISOR_W
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ce,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] din0,
  input  logic signed [DIVISOR_WIDTH-1:0]  din1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DIVIDEND_WIDTH-1:0] quot,
  output logic signed [DIVISOR_WIDTH-1:0]  rem,
  output logic                             dbz,
  output logic                             ovf
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = SDIV_CNT_W;

  // ID is a tag only; folding it in as zero keeps it referenced without effect.
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1 + ID - ID);
  localparam logic [DW-1:0] QUOT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] QUOT_MAX = {1'b0, {(DW-1){1'b1}}};

  sdiv_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] prem_q, prem_d;
  logic [VW-1:0] dmag_q, dmag_d;
  logic          neg_a_q, neg_a_d;
  logic          neg_b_q, neg_b_d;
  logic          zdiv_q, zdiv_d;
  logic          oflow_q, oflow_d;
  logic [DW-1:0] qs_q, qs_d;
  logic [VW-1:0] rs_q, rs_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic [VW-1:0] step_rem;
  logic          step_q;

  assign a_mag = din0[DW-1] ? -din0 : din0;
  assign b_mag = din1[VW-1] ? -din1 : din1;

  // The dividend register shifts out magnitude bits at the top and collects quotient bits at the bottom.
  myproject_sdiv_step #(
    .W(VW)
  ) u_step (
    .rem_i(prem_q),
    .bit_i(dvd_q[DW-1]),
    .div_i(dmag_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dmag_d  = dmag_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    zdiv_d  = zdiv_q;
    oflow_d = oflow_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          dvd_d   = a_mag;
          prem_d  = '0;
          dmag_d  = b_mag;
          neg_a_d = din0[DW-1];
          neg_b_d = din1[VW-1];
          zdiv_d  = (din1 == '0);
          oflow_d = (din0 == QUOT_MIN) && (din1 == '1);
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[DW-2:0], step_q};
        prem_d = step_rem;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        // Negation and result selection are split over two cycles to keep each path short.
        if (cnt_q == '0) begin
          qs_d  = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
          rs_d  = neg_a_q ? -prem_q : prem_q;
          cnt_d = CW'(1);
        end else begin
          state_d = DONE;
          cnt_d   = '0;
          if (zdiv_q) begin
            quot_d = '0;
            rem_d  = '0;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
          end else if (oflow_q) begin
`ifdef MYPROJECT_SDIV_SAT_EN
            quot_d = QUOT_MAX;
`else
            quot_d = QUOT_MIN;
`endif
            rem_d  = '0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b1;
          end else begin
            quot_d = qs_q;
            rem_d  = rs_q;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dmag_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zdiv_q  <= 1'b0;
      oflow_q <= 1'b0;
      qs_q    <= '0;
      rs_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dmag_q  <= dmag_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      zdiv_q  <= zdiv_d;
      oflow_q <= oflow_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_myproject_sdiv_24s_9s_seq.sv
// Bench for the sequential signed divider: vector table, handshake corner cases, randomized ops vs. arithmetic model.
module tb_myproject_sdiv_24s_9s_seq;

  localparam int DW = 24;
  localparam int VW = 9;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 ce;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] din0;
  logic signed [VW-1:0] din1;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] quot;
  logic signed [VW-1:0] rem;
  logic                 dbz;
  logic                 ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  myproject_sdiv_24s_9s_seq #(
    .ID(1),
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH(VW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
    .rem      (rem),
    .dbz      (dbz),
    .ovf      (ovf)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dz;
    bit ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truncating signed division as plain integer arithmetic.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output bit dz, output bit ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = 0;
      r  = 0;
      dz = 1'b1;
    end else if (a == -8388608 && b == -1) begin
      r  = 0;
      ov = 1'b1;
`ifdef MYPROJECT_SDIV_SAT_EN
      q = 8388607;
`else
      q = -8388608;
`endif
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input int a, input int b, output int lat, output longint q,
                        output longint r, output bit dz, output bit ov);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    din0     = a[DW-1:0];
    din1     = b[VW-1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    q  = quot;
    r  = rem;
    dz = dbz;
    ov = ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int     lat;
    longint q, r;
    bit     dz, ov;
    int     eq, er;
    bit     edz, eov;
    int     bad;

    vecs[0] = '{1000, 7, 142, 6, 1'b0, 1'b0};
    vecs[1] = '{-1000, 7, -142, -6, 1'b0, 1'b0};
    vecs[2] = '{1000, -7, -142, 6, 1'b0, 1'b0};
    vecs[3] = '{-1000, -7, 142, -6, 1'b0, 1'b0};
    vecs[4] = '{5, 0, 0, 0, 1'b1, 1'b0};
`ifdef MYPROJECT_SDIV_SAT_EN
    vecs[5] = '{-8388608, -1, 8388607, 0, 1'b0, 1'b1};
`else
    vecs[5] = '{-8388608, -1, -8388608, 0, 1'b0, 1'b1};
`endif
    vecs[6] = '{8388607, 255, 32896, 127, 1'b0, 1'b0};
    vecs[7] = '{-8388608, -256, 32768, 0, 1'b0, 1'b0};
    vecs[8] = '{-7, 100, 0, -7, 1'b0, 1'b0};
    vecs[9] = '{123, -1, -123, 0, 1'b0, 1'b0};

    reset_n   = 1'b0;
    ce        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    #3 reset_n = 1'b1;
    ce = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, q, r, dz, ov);
      chk($sformatf("vec%0d_lat", i), lat, 26);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
      release_out();
      chk($sformatf("vec%0d_ready_after", i), in_ready, 1);
    end

    // ce low for three cycles mid-CALC, new operands offered throughout, result held 10 cycles.
    din0     = 24'sd1000;
    din1     = 9'sd7;
    in_valid = 1'b1;
    tick();
    din0 = 24'sd50;
    din1 = 9'sd3;
    lat  = 0;
    bad  = 0;
    while (!out_valid && lat < 80) begin
      ce = !(lat >= 5 && lat < 8);
      tick();
      lat++;
      if (in_ready) bad++;
    end
    ce = 1'b1;
    chk("ce_stall_lat", lat, 29);
    chk("ce_stall_no_accept", bad, 0);
    chk("ce_stall_quot", quot, 142);
    chk("ce_stall_rem", rem, 6);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!out_valid || quot != 24'sd142 || rem != 9'sd6 || in_ready || dbz || ovf) bad++;
    end
    chk("hold_stable", bad, 0);
    in_valid  = 1'b0;
    ce        = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_ce_low_valid", out_valid, 1);
    ce = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);
    repeat (3) tick();
    chk("no_second_accept", in_ready, 1);

    // Leave a non-zero result, then reset in the middle of the next calculation.
    run_op(1000, -7, lat, q, r, dz, ov);
    chk("pre_rst_quot", q, -142);
    release_out();
    din0     = -24'sd1000;
    din1     = 9'sd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_quot", quot, 0);
    chk("mid_rst_rem", rem, 0);
    chk("mid_rst_dbz", dbz, 0);
    chk("mid_rst_ovf", ovf, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    run_op(8388607, 255, lat, q, r, dz, ov);
    chk("post_rst_lat", lat, 26);
    chk("post_rst_quot", q, 32896);
    chk("post_rst_rem", r, 127);
    release_out();

    for (int i = 0; i < 60; i++) begin
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;
      int a, b;
      ra = DW'($urandom);
      rb = VW'($urandom);
      a  = int'($signed(ra));
      b  = int'($signed(rb));
      if (i % 10 == 3) b = 0;
      if (i % 10 == 7) begin
        a = -8388608;
        b = -1;
      end
      if (i % 10 == 5) a = int'($signed(ra[11:0]));
      model(a, b, eq, er, edz, eov);
      run_op(a, b, lat, q, r, dz, ov);
      chk($sformatf("rnd%0d_lat", i), lat, 26);
      chk($sformatf("rnd%0d_quot a=%0d b=%0d", i, a, b), q, eq);
      chk($sformatf("rnd%0d_rem a=%0d b=%0d", i, a, b), r, er);
      chk($sformatf("rnd%0d_dbz", i), dz, edz);
      chk($sformatf("rnd%0d_ovf", i), ov, eov);
      release_out();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
